mem_copy_engine: RTL and testbench
==================================

MEM_COPY_ENGINE -- requirements
Module: mem_copy_engine

Interface
REQ-001 Parameter AW, default 8, address width in bits.
REQ-002 Parameter DW, default 8, data width in bits.
REQ-003 The block SHALL use one clock; reset is asynchronous and active-low.
REQ-004 Clk  input  1  clock; all state changes on rising edge.
REQ-005 Rst_n  input  1  asynchronous active-low reset.
REQ-006 Start  input  1  command strobe; sampled only in IDLE.
REQ-007 SrcAddr  input  AW  first source address, captured on accepted Start.
REQ-008 DstAddr  input  AW  first destination address, captured on accepted Start.
REQ-009 Len  input  AW+1  byte count, 0..2^AW, captured on accepted Start.
REQ-010 ReadData  input  DW  memory read data; combinational from Address while MemRead=1.
REQ-011 Address  output  AW  memory address.
REQ-012 WriteData  output  DW  memory write data.
REQ-013 MemRead  output  1  memory read enable.
REQ-014 MemWrite  output  1  memory write enable; memory writes on Clk rising edge.
REQ-015 Busy  output  1  high in every state except IDLE.
REQ-016 Done  output  1  one-cycle completion pulse.
REQ-017 Checksum  output  DW  mod-2^DW sum of bytes copied by the last command.

Function
REQ-018 The FSM SHALL have states IDLE, READ, WRITE and FIN.
REQ-019 IDLE with Start=1 SHALL capture SrcAddr, DstAddr and Len, clear idx and Checksum, and go to FIN if Len=0, else to READ.
REQ-020 READ SHALL drive MemRead=1 and Address=src+idx, latch ReadData into a byte buffer, add it to Checksum, and go to WRITE.
REQ-021 WRITE SHALL drive MemWrite=1, Address=dst+idx and WriteData=buffer, then increment idx and go to FIN if idx+1=Len, else to READ.
REQ-022 FIN SHALL assert Done for exactly one cycle and return to IDLE.
REQ-023 MemRead and MemWrite SHALL never be asserted in the same cycle; both SHALL be 0 in IDLE and FIN.
REQ-024 Address, WriteData and the enables SHALL be Moore outputs decoded from state and registers only, with no combinational path from inputs.
REQ-025 Address arithmetic SHALL be modulo 2^AW, so copies wrap from 255 to 0.
REQ-026 Throughput SHALL be 2 cycles per byte; total latency from accepted Start to Done SHALL be 2*Len+1 cycles (1 cycle when Len=0).
REQ-027 Start while Busy=1 SHALL be ignored, and captured operands SHALL not change mid-command.
REQ-028 Bytes SHALL be copied in ascending order, giving forward-copy semantics for overlapping regions.
REQ-029 Len=2^AW SHALL copy the whole memory exactly once.
REQ-030 Checksum SHALL hold its value after FIN until the next accepted Start.
REQ-031 Start asserted in the Done cycle SHALL be ignored; Start is accepted in IDLE only.

Reset
REQ-032 Rst_n=0 SHALL immediately force IDLE and Address=0, WriteData=0, MemRead=0, MemWrite=0, Busy=0, Done=0, Checksum=0.
REQ-033 Reset during WRITE SHALL deassert MemWrite asynchronously; the in-flight byte is not guaranteed, and no later writes SHALL occur.
REQ-034 After reset release, the block SHALL idle until a new Start.

Structure
REQ-035 The state encoding and the AW/DW defaults SHALL live in shared package mem_pkg.
REQ-036 The block SHALL be a single module with no sub-module.
REQ-037 Benches SHALL connect the block to the team's 256x8 data memory, which has synchronous write and combinational read.

Verification
REQ-038 Preload mem[0x10..0x13]=01,02,03,04; Start Src=0x10 Dst=0x80 Len=4 -> mem[0x80..0x83]=01..04, Done at cycle 9 after Start, Checksum=0x0A.
REQ-039 Start with Len=0 -> Done one cycle later, no MemRead/MemWrite pulses, Checksum=0.
REQ-040 Src=0xFE Dst=0x01 Len=3 with mem[FE,FF,00]=AA,BB,CC -> mem[01..03]=AA,BB,CC (source wrap verified).
REQ-041 Second Start pulsed mid-copy with different operands -> ignored; first copy completes unchanged.
REQ-042 Rst_n low during the third WRITE of an 8-byte copy -> outputs zero at once, no further writes, Busy=0; a new Start then runs correctly.
REQ-043 Overlap Src=0x20 Dst=0x21 Len=4 with mem[0x20]=55 -> mem[0x21..0x24]=55 (forward-copy smear).

Source files
------------

// File: rtl/mem_pkg.sv
`default_nettype none
// mem_pkg -- shared defaults and state encoding for the memory copy engine.
// Rev 1.0
package mem_pkg;

  localparam int AW_DEFAULT = 8;
  localparam int DW_DEFAULT = 8;

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_READ  = 2'd1;
  localparam logic [1:0] ST_WRITE = 2'd2;
  localparam logic [1:0] ST_FIN   = 2'd3;

endpackage
`default_nettype wire

// File: rtl/mem_copy_engine.sv
`default_nettype none
// mem_copy_engine -- byte-wise forward memory copy, two cycles per byte, running checksum.
// Rev 1.0
module mem_copy_engine
  import mem_pkg::*;
#(
  parameter int AW = AW_DEFAULT,
  parameter int DW = DW_DEFAULT
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          start,
  input  logic [AW-1:0] src_addr,
  input  logic [AW-1:0] dst_addr,
  input  logic [AW:0]   len,
  input  logic [DW-1:0] read_data,
  output logic [AW-1:0] address,
  output logic [DW-1:0] write_data,
  output logic          mem_read,
  output logic          mem_write,
  output logic          busy,
  output logic          done,
  output logic [DW-1:0] checksum
);

  logic [1:0]    state;
  logic [1:0]    next_state;
  logic [AW-1:0] src;
  logic [AW-1:0] dst;
  logic [AW:0]   len_q;
  logic [AW:0]   idx;
  logic [AW:0]   idx_next;
  logic [DW-1:0] buffer;

  // idx is one bit wider than an address so a full-memory length terminates.
  assign idx_next = idx + {{AW{1'b0}}, 1'b1};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= ST_IDLE;
    end else begin
      state <= next_state;
    end
  end

  always_comb begin
    next_state = state;
    case (state)
      ST_IDLE: begin
        if (start) begin
          next_state = (len == '0) ? ST_FIN : ST_READ;
        end
      end
      ST_READ:  next_state = ST_WRITE;
      ST_WRITE: next_state = (idx_next == len_q) ? ST_FIN : ST_READ;
      ST_FIN:   next_state = ST_IDLE;
      default:  next_state = ST_IDLE;
    endcase
  end

  always_comb begin
    busy       = (state != ST_IDLE);
    done       = (state == ST_FIN);
    mem_read   = (state == ST_READ);
    mem_write  = (state == ST_WRITE);
    address    = '0;
    write_data = '0;
    case (state)
      ST_READ:  address = src + idx[AW-1:0];
      ST_WRITE: begin
        address    = dst + idx[AW-1:0];
        write_data = buffer;
      end
      default: begin
        address    = '0;
        write_data = '0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      src      <= '0;
      dst      <= '0;
      len_q    <= '0;
      idx      <= '0;
      buffer   <= '0;
      checksum <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (start) begin
            src      <= src_addr;
            dst      <= dst_addr;
            len_q    <= len;
            idx      <= '0;
            checksum <= '0;
          end
        end
        ST_READ: begin
          buffer   <= read_data;
          checksum <= checksum + read_data;
        end
        ST_WRITE: idx <= idx_next;
        default: ;
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_mem_copy_engine.sv
`default_nettype none
// tb_mem_copy_engine -- randomized and directed checks of the copy engine against a sequential copy model.
// Rev 1.0
module tb_mem_copy_engine;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       start = 1'b0;
  logic [7:0] src_addr = '0;
  logic [7:0] dst_addr = '0;
  logic [8:0] len = '0;
  logic [7:0] read_data;
  logic [7:0] address;
  logic [7:0] write_data;
  logic       mem_read;
  logic       mem_write;
  logic       busy;
  logic       done;
  logic [7:0] checksum;

  logic [7:0] mem [256];
  logic [7:0] ref_mem [256];
  logic       tb_we = 1'b0;
  logic [7:0] tb_addr = '0;
  logic [7:0] tb_data = '0;

  int n_checks = 0;
  int n_errors = 0;
  int rd_cnt = 0;
  int wr_cnt = 0;
  int excl_viol = 0;
  int skip_addr = -1;

  mem_copy_engine #(.AW(8), .DW(8)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .start      (start),
    .src_addr   (src_addr),
    .dst_addr   (dst_addr),
    .len        (len),
    .read_data  (read_data),
    .address    (address),
    .write_data (write_data),
    .mem_read   (mem_read),
    .mem_write  (mem_write),
    .busy       (busy),
    .done       (done),
    .checksum   (checksum)
  );

  always #5 clk = ~clk;

  // 256x8 data memory: synchronous write, combinational read.
  assign read_data = mem[address];
  always @(posedge clk) begin
    if (mem_write) mem[address] <= write_data;
    else if (tb_we) mem[tb_addr] <= tb_data;
  end

  always @(negedge clk) begin
    if (mem_read && mem_write) excl_viol++;
    if (mem_read) rd_cnt++;
    if (mem_write) wr_cnt++;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic poke(input int a, input logic [7:0] v);
    tb_we = 1'b1;
    tb_addr = a[7:0];
    tb_data = v;
    @(posedge clk);
    #1 tb_we = 1'b0;
    ref_mem[a & 255] = v;
  endtask

  task automatic check_mem(input string tag);
    int bad = 0;
    for (int a = 0; a < 256; a++) begin
      if (a != skip_addr && mem[a] !== ref_mem[a]) bad++;
    end
    check(tag, bad, 0);
  endtask

  // Reference: bytes move one at a time in ascending order, so overlaps smear forward.
  task automatic model_copy(input int s, input int d, input int l, output logic [7:0] sum);
    sum = '0;
    for (int i = 0; i < l; i++) begin
      sum = sum + ref_mem[(s + i) & 255];
      ref_mem[(d + i) & 255] = ref_mem[(s + i) & 255];
    end
  endtask

  task automatic run_copy(input string tag, input int s, input int d, input int l, input bit inject);
    int cyc = 0;
    int rd0 = rd_cnt;
    int wr0 = wr_cnt;
    logic [7:0] sum;
    model_copy(s, d, l, sum);
    src_addr = s[7:0];
    dst_addr = d[7:0];
    len = l[8:0];
    start = 1'b1;
    do begin
      @(posedge clk);
      #1;
      cyc++;
      if (cyc == 1) start = 1'b0;
      if (inject && cyc == 3) begin
        start = 1'b1;
        src_addr = src_addr + 8'd7;
        dst_addr = dst_addr + 8'd9;
        len = 9'd2;
      end
      if (inject && cyc == 4) start = 1'b0;
    end while (!done && cyc < 600);
    check({tag, "_latency"}, cyc, 2 * l + 1);
    check({tag, "_checksum"}, checksum, sum);
    check({tag, "_reads"}, rd_cnt - rd0, l);
    check({tag, "_writes"}, wr_cnt - wr0, l);
    // A start held during the done cycle must not launch a command.
    start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    check({tag, "_idle_after"}, {busy, done}, 2'b00);
    @(posedge clk);
    #1;
    check({tag, "_cs_hold"}, checksum, sum);
    check_mem({tag, "_mem"});
  endtask

  initial begin
    logic [7:0] dummy;
    int cyc;
    int wr0;

    start = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check("reset_outputs", {address, write_data, mem_read, mem_write, busy, done, checksum},
          '0);
    start = 1'b0;
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    check("idle_after_reset", busy, 1'b0);

    for (int a = 0; a < 256; a++) poke(a, 8'($urandom));

    poke(8'h10, 8'h01); poke(8'h11, 8'h02); poke(8'h12, 8'h03); poke(8'h13, 8'h04);
    run_copy("basic", 8'h10, 8'h80, 4, 1'b0);
    check("basic_cs_const", checksum, 8'h0A);
    check("basic_dst", {mem[8'h80], mem[8'h81], mem[8'h82], mem[8'h83]}, 32'h01020304);

    run_copy("len0", 8'h33, 8'h44, 0, 1'b0);
    check("len0_cs_const", checksum, 8'h00);

    poke(8'hFE, 8'hAA); poke(8'hFF, 8'hBB); poke(8'h00, 8'hCC);
    run_copy("wrap", 8'hFE, 8'h01, 3, 1'b0);
    check("wrap_dst", {mem[1], mem[2], mem[3]}, 24'hAABBCC);

    run_copy("ignore_start", 8'h40, 8'hA0, 6, 1'b1);

    poke(8'h20, 8'h55);
    run_copy("overlap", 8'h20, 8'h21, 4, 1'b0);
    check("overlap_last", mem[8'h24], 8'h55);

    // Reset during the third WRITE of an 8-byte copy.
    wr0 = wr_cnt;
    src_addr = 8'h50;
    dst_addr = 8'hC0;
    len = 9'd8;
    start = 1'b1;
    cyc = 0;
    do begin
      @(posedge clk);
      #1;
      cyc++;
      if (cyc == 1) start = 1'b0;
    end while (cyc < 6);
    check("rst_w3_active", mem_write, 1'b1);
    #1 rst_n = 1'b0;
    #1;
    check("rst_outputs", {address, write_data, mem_read, mem_write, busy, done, checksum}, '0);
    repeat (3) @(posedge clk);
    #1;
    check("rst_no_writes", wr_cnt - wr0, 2);
    ref_mem[8'hC0] = ref_mem[8'h50];
    ref_mem[8'hC1] = ref_mem[8'h51];
    skip_addr = 8'hC2;
    rst_n = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    check("rst_stays_idle", {busy, mem_read, mem_write}, 3'b000);
    run_copy("after_rst", 8'h60, 8'h70, 5, 1'b0);

    for (int t = 0; t < 15; t++) begin
      int l;
      l = ($urandom_range(0, 3) == 0) ? 0 : int'($urandom_range(1, 48));
      run_copy("rand", int'($urandom_range(0, 255)), int'($urandom_range(0, 255)), l, 1'b0);
    end

    run_copy("full", int'($urandom_range(0, 255)), int'($urandom_range(0, 255)), 256, 1'b0);

    check("excl_rd_wr", excl_viol, 0);
    model_copy(0, 0, 0, dummy);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
`default_nettype wire
